mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single system clock, rising edge; reset  in  1  asynchronous, active-low reset.
REQ-002 SHALL have fetch-side ports: if_req  in  1  IF stage read request; if_addr  in  32  byte address; if_rdata  out  32  fetched word; if_ready  out  1  one-cycle completion pulse.
REQ-003 SHALL have data-side ports: mem_rd  in  1  load request; mem_wr  in  1  store request; mem_addr  in  32  byte address; mem_wdata  in  32  store data; mem_rdata  out  32  load data; mem_ready  out  1  one-cycle completion pulse.
REQ-004 SHALL have RAM-side ports: ram_req  out  1  access strobe; ram_we  out  1  write enable; ram_addr  out  30  word address; ram_wdata  out  32; ram_rdata  in  32; ram_ack  in  1  one-cycle completion from the single-port unified RAM.
REQ-005 SHALL have status ports: stall_if  out  1; stall_mem  out  1; err  out  1  sticky protocol/timeout flag.
REQ-006 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of ram_req cycles without ram_ack before err is set.

Function
REQ-007 SHALL arbitrate one single-port RAM between IF (if_req) and MEM (mem_rd|mem_wr); at most one access outstanding.
REQ-008 SHALL implement states IDLE, DATA, FETCH, DONE.
REQ-009 IDLE: if mem_rd|mem_wr -> DATA; else if if_req -> FETCH; else stay; data side always wins simultaneous requests (older instruction).
REQ-010 On the IDLE->DATA/FETCH transition SHALL register ram_addr = addr[31:2], ram_wdata, ram_we (= mem_wr in DATA, 0 in FETCH); these hold constant until exit.
REQ-011 DATA/FETCH: ram_req = 1 (registered); on ram_ack capture ram_rdata into the requester's read register and -> DONE; otherwise stay.
REQ-012 DONE: lasts exactly one cycle; asserts mem_ready (if served DATA) or if_ready (if served FETCH), never both; -> IDLE.
REQ-013 Latency: request sampled in cycle 0, ram_req in cycle 1, ack no earlier than cycle 1, ready no earlier than cycle 2; minimum 3 cycles between two successive grants.
REQ-014 mem_rd and mem_wr both high SHALL be treated as a store; address low bits [1:0] are ignored.
REQ-015 if_rdata/mem_rdata SHALL hold their last captured value until the next capture for the same side; a store leaves mem_rdata unchanged.
REQ-016 stall_if = if_req & ~if_ready; stall_mem = (mem_rd|mem_wr) & ~mem_ready; both combinational.
REQ-017 Requesters hold request and operands stable until their ready pulse; arbiter does not re-sample operands while in DATA/FETCH.
REQ-018 ram_ack while in IDLE or DONE SHALL be ignored and set err.
REQ-019 Wait counter: cleared on entry to DATA/FETCH, increments each ram_req cycle without ack; reaching TIMEOUT sets err; arbiter keeps waiting (no abort), counter saturates.
REQ-020 err is sticky; cleared only by reset.

Reset
REQ-021 On reset low, asynchronously: state IDLE, ram_req 0, ram_we 0, ram_addr 0, ram_wdata 0, if_rdata 0, mem_rdata 0, if_ready 0, mem_ready 0, err 0, counter 0.
REQ-022 Reset mid-access SHALL drop ram_req immediately and discard the access; no ready pulse is generated for it after reset release.
REQ-023 First arbitration decision SHALL occur on the first rising clk edge after reset deasserts.

Structure
REQ-024 State encoding (2-bit IDLE=0, DATA=1, FETCH=2, DONE=3) and the default TIMEOUT SHALL live in the shared CPU package.
REQ-025 The saturating wait counter SHALL be a sub-module wait_timer (inputs clear, enable; output expired).
REQ-026 Implementation target 120-400 lines RTL; no memory arrays inside.

Verification
REQ-027 if_req=1, if_addr=0x0000_0010, ram_ack one cycle after ram_req with ram_rdata=0x2408_0005 -> ram_addr=0x4, if_ready pulse cycle 3, if_rdata=0x2408_0005.
REQ-028 if_req and mem_rd both raised same cycle, mem_addr=0x100 -> DATA served first (ram_addr=0x40), mem_ready precedes if_ready, fetch granted next.
REQ-029 mem_wr=1, mem_addr=0x20, mem_wdata=0xDEAD_BEEF, ack after 4 cycles -> ram_we=1, ram_wdata=0xDEAD_BEEF, mem_ready once, mem_rdata unchanged, stall_mem high 6 cycles.
REQ-030 reset low during FETCH with ack not yet given -> ram_req 0 immediately, no if_ready after release, state IDLE.
REQ-031 TIMEOUT=4, ack withheld 10 cycles -> err=1 after 4 waiting cycles, stays 1; late ack still completes the access.
REQ-032 ram_ack pulsed while IDLE -> err=1, no ready pulse, outputs otherwise unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: arbiter state encoding and timing defaults.
package mem_arbiter_pkg;

  // Arbiter FSM states; the encoding is relied on by debug tooling.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Default number of unacknowledged ram_req cycles before err is raised.
  localparam int TIMEOUT_DEFAULT = 255;

  // Byte address to RAM word address.
  function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// Saturating wait counter: counts enabled cycles up to LIMIT and holds there.
module wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step until the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIM)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one single-port unified RAM.
// Handshake: a requester raises its request with stable operands and holds
// them until its one-cycle ready pulse; the RAM answers an asserted ram_req
// with a one-cycle ram_ack. Only one RAM access is outstanding at a time and
// the data side wins simultaneous requests.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        ram_req,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err,
  output arb_state_e  dbg_state
);

  arb_state_e  state_q, state_d;
  logic        served_mem_q;
  logic        ram_req_q, ram_we_q;
  logic [29:0] ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic [31:0] if_rdata_q, mem_rdata_q;
  logic        if_ready_q, mem_ready_q;
  logic        err_q;

  logic grant_mem, grant_if, ack_take, bad_ack;
  logic timer_expired;

  // Byte-offset bits are deliberately ignored.
  logic unused_low_bits;
  assign unused_low_bits = ^{if_addr[1:0], mem_addr[1:0]};

  // Next-state and grant decode; the data side is checked first.
  always_comb begin
    state_d   = state_q;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    ack_take  = 1'b0;
    bad_ack   = 1'b0;
    case (state_q)
      IDLE: begin
        bad_ack = ram_ack;
        if (mem_rd || mem_wr) begin
          state_d   = DATA;
          grant_mem = 1'b1;
        end else if (if_req) begin
          state_d  = FETCH;
          grant_if = 1'b1;
        end
      end
      DATA, FETCH: begin
        if (ram_ack) begin
          state_d  = DONE;
          ack_take = 1'b1;
        end
      end
      DONE: begin
        bad_ack = ram_ack;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // RAM command, read capture, ready pulses and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      served_mem_q <= 1'b0;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if (grant_mem || grant_if) begin
        served_mem_q <= grant_mem;
        ram_req_q    <= 1'b1;
        ram_we_q     <= grant_mem & mem_wr;
        ram_addr_q   <= grant_mem ? word_addr(mem_addr) : word_addr(if_addr);
        ram_wdata_q  <= mem_wdata;
      end
      if (ack_take) begin
        ram_req_q <= 1'b0;
        if (served_mem_q) begin
          mem_ready_q <= 1'b1;
          if (!ram_we_q) mem_rdata_q <= ram_rdata;
        end else begin
          if_ready_q <= 1'b1;
          if_rdata_q <= ram_rdata;
        end
      end
      err_q <= err_q | bad_ack | timer_expired;
    end
  end

  wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant_mem | grant_if),
    .enable  (ram_req_q & ~ram_ack),
    .expired (timer_expired)
  );

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = (mem_rd | mem_wr) & ~mem_ready_q;
  assign err       = err_q | timer_expired;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural RAM responder.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        if_req = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [31:0] if_rdata, mem_rdata, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        if_ready, mem_ready, ram_req, ram_we, stall_if, stall_mem, err;
  logic [29:0] ram_addr;
  logic        ram_ack, model_ack = 1'b0, force_ack = 1'b0;
  arb_state_e  dbg_state;
  assign ram_ack = model_ack | force_ack;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];        // {served_data_side, expected read register}
  logic [31:0] mem_model = '0;  // expected mem_rdata
  logic [29:0] grant_addr_q[$];
  logic        obs_we = 1'b0;
  logic [31:0] obs_wdata = '0;
  int          ack_delay = 1;

  function automatic logic [31:0] ram_word(input logic [29:0] a);
    if (a == 30'h4) return 32'h2408_0005;
    return {a, 2'b01} ^ 32'hC3C3_0000;
  endfunction

  // ---------------- RAM responder ----------------
  initial begin
    bit alive;
    forever begin
      @(posedge clk); #2;
      if (reset && ram_req) begin
        grant_addr_q.push_back(ram_addr);
        obs_we    = ram_we;
        obs_wdata = ram_wdata;
        alive = 1'b1;
        for (int i = 0; i < ack_delay; i++) begin
          @(posedge clk); #2;
          if (!ram_req) begin alive = 1'b0; break; end
        end
        if (alive) begin
          ram_rdata = ram_word(ram_addr);
          model_ack = 1'b1;
          @(posedge clk); #2;
          model_ack = 1'b0;
        end
      end
    end
  end

  // ---------------- ready monitor ----------------
  always @(negedge clk) begin
    if (reset && (if_ready || mem_ready)) begin
      logic [32:0] e;
      logic [32:0] got;
      total++;
      got = mem_ready ? {1'b1, mem_rdata} : {1'b0, if_rdata};
      if (if_ready && mem_ready) begin
        bad++; $display("FAIL both_ready got=11 exp=one_side");
      end else if (exp_q.size() == 0) begin
        bad++; $display("FAIL unexpected_ready got=%h exp=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++; $display("FAIL ready_data got=%h exp=%h", got, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b0;
    if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; force_ack = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; ack_delay = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    mem_model = '0;
    exp_q.delete();
    grant_addr_q.delete();
  endtask

  task automatic run_access(input bit is_mem, input bit rd, input bit wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int delay, output int lat, output int stalls);
    int start;
    ack_delay = delay;
    if (is_mem) begin
      mem_rd = rd; mem_wr = wr; mem_addr = addr; mem_wdata = wdata;
      if (!wr) mem_model = ram_word(addr[31:2]);
      exp_q.push_back({1'b1, mem_model});
    end else begin
      if_req = 1'b1; if_addr = addr;
      exp_q.push_back({1'b0, ram_word(addr[31:2])});
    end
    start = cyc; lat = -1; stalls = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (is_mem ? stall_mem : stall_if) stalls++;
      if (is_mem ? mem_ready : if_ready) begin lat = cyc - start; break; end
    end
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0; if_req = 1'b0;
    total++;
    if (lat < 0) begin bad++; $display("FAIL access_timeout got=none exp=ready"); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if ({ram_req, ram_we, if_ready, mem_ready, err} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {ram_req, ram_we, if_ready, mem_ready, err}); end
    total++; if ({ram_addr, ram_wdata} !== 62'h0) begin
      bad++; $display("FAIL reset_ram_cmd got=%h exp=0", {ram_addr, ram_wdata}); end
    total++; if ({if_rdata, mem_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, mem_rdata}); end
    total++; if (dbg_state !== IDLE) begin
      bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_fetch();
    int lat, st;
    do_reset();
    run_access(1'b0, 1'b0, 1'b0, 32'h0000_0010, '0, 1, lat, st);
    total++; if (lat != 3) begin bad++; $display("FAIL fetch_latency got=%0d exp=3", lat); end
    total++; if (st != 3) begin bad++; $display("FAIL fetch_stall got=%0d exp=3", st); end
    total++; if (grant_addr_q.size() != 1 || grant_addr_q[0] !== 30'h4) begin
      bad++; $display("FAIL fetch_addr got=%0d entries exp=addr 4", grant_addr_q.size()); end
    total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL fetch_we got=%b exp=0", obs_we); end
    total++; if (if_rdata !== 32'h2408_0005) begin
      bad++; $display("FAIL fetch_rdata got=%h exp=24080005", if_rdata); end
  endtask

  task automatic test_priority();
    int c0, mc, ic;
    do_reset();
    ack_delay = 1;
    if_req = 1'b1; if_addr = 32'h200; mem_rd = 1'b1; mem_addr = 32'h100;
    mem_model = ram_word(30'h40);
    exp_q.push_back({1'b1, ram_word(30'h40)});
    exp_q.push_back({1'b0, ram_word(30'h80)});
    c0 = cyc; mc = -1; ic = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_ready && mc < 0) mc = cyc;
      if (if_ready && ic < 0) ic = cyc;
      @(posedge clk); #1;
      if (mc >= 0) mem_rd = 1'b0;
      if (ic >= 0) if_req = 1'b0;
      if (mc >= 0 && ic >= 0) break;
    end
    total++; if (mc - c0 != 3) begin bad++; $display("FAIL prio_mem_latency got=%0d exp=3", mc - c0); end
    total++; if (ic - mc != 4) begin bad++; $display("FAIL prio_fetch_gap got=%0d exp=4", ic - mc); end
    total++; if (grant_addr_q.size() != 2 || grant_addr_q[0] !== 30'h40 || grant_addr_q[1] !== 30'h80) begin
      bad++; $display("FAIL prio_order got=%0d grants exp=40 then 80", grant_addr_q.size()); end
  endtask

  task automatic test_store();
    int lat, st;
    do_reset();
    run_access(1'b1, 1'b1, 1'b0, 32'h0000_0023, '0, 2, lat, st);
    total++; if (lat != 4) begin bad++; $display("FAIL load_latency got=%0d exp=4", lat); end
    total++; if (grant_addr_q.size() < 1 || grant_addr_q[0] !== 30'h8) begin
      bad++; $display("FAIL load_addr got=%0d entries exp=addr 8", grant_addr_q.size()); end
    total++; if (mem_rdata !== ram_word(30'h8)) begin
      bad++; $display("FAIL load_rdata got=%h exp=%h", mem_rdata, ram_word(30'h8)); end
    run_access(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4, lat, st);
    total++; if (obs_we !== 1'b1 || obs_wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL store_cmd got=%b/%h exp=1/deadbeef", obs_we, obs_wdata); end
    total++; if (st != 6) begin bad++; $display("FAIL store_stall got=%0d exp=6", st); end
    total++; if (grant_addr_q.size() < 2 || grant_addr_q[1] !== 30'h8) begin
      bad++; $display("FAIL store_addr got=%0d entries exp=addr 8", grant_addr_q.size()); end
    total++; if (mem_rdata !== ram_word(30'h8)) begin
      bad++; $display("FAIL store_keeps_rdata got=%h exp=%h", mem_rdata, ram_word(30'h8)); end
    run_access(1'b1, 1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678, 0, lat, st);
    total++; if (obs_we !== 1'b1 || obs_wdata !== 32'h1234_5678) begin
      bad++; $display("FAIL rdwr_is_store got=%b/%h exp=1/12345678", obs_we, obs_wdata); end
    total++; if (lat != 2) begin bad++; $display("FAIL rdwr_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    ack_delay = 20;
    if_req = 1'b1; if_addr = 32'h30;
    repeat (2) begin @(posedge clk); #1; end
    total++; if (ram_req !== 1'b1 || dbg_state !== FETCH) begin
      bad++; $display("FAIL midrst_pre got=%b/%0d exp=1/%0d", ram_req, dbg_state, FETCH); end
    #3;
    reset = 1'b0;
    if_req = 1'b0;
    #1;
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b exp=0", ram_req); end
    total++; if (dbg_state !== IDLE || err !== 1'b0) begin
      bad++; $display("FAIL midrst_state got=%0d/%b exp=%0d/0", dbg_state, err, IDLE); end
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_ready || ram_req) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_no_ready got=%0d exp=0", seen); end
  endtask

  task automatic test_timeout();
    int c0, lat;
    bit exp_err;
    do_reset();
    ack_delay = 10;
    if_req = 1'b1; if_addr = 32'h50;
    exp_q.push_back({1'b0, ram_word(30'h14)});
    c0 = cyc; lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp_err = (cyc - c0) >= 5;
      total++; if (err !== exp_err) begin
        bad++; $display("FAIL timeout_err cycle=%0d got=%b exp=%b", cyc - c0, err, exp_err); end
      if (if_ready) begin lat = cyc - c0; break; end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    total++; if (lat != 12) begin bad++; $display("FAIL timeout_late_ack got=%0d exp=12", lat); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", err); end
  endtask

  task automatic test_bad_ack();
    int lat, st, seen;
    do_reset();
    run_access(1'b0, 1'b0, 1'b0, 32'h0000_0010, '0, 1, lat, st);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL badack_pre got=%b exp=0", err); end
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL badack_err got=%b exp=1", err); end
    total++; if (ram_req !== 1'b0 || dbg_state !== IDLE) begin
      bad++; $display("FAIL badack_state got=%b/%0d exp=0/%0d", ram_req, dbg_state, IDLE); end
    total++; if (if_rdata !== 32'h2408_0005 || mem_rdata !== 32'h0) begin
      bad++; $display("FAIL badack_rdata got=%h/%h exp=24080005/0", if_rdata, mem_rdata); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_ready || mem_ready) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL badack_ready got=%0d exp=0", seen); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL badack_sticky got=%b exp=1", err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_reset_mid();
    test_timeout();
    test_bad_ack();
    repeat (2) @(posedge clk);
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover_expected got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
